// File: rtl/error_buffer_ctrl.sv
// Error-report front end: one-deep pending slot per source, round-robin
// arbitration into error_buffer's write port, saturating drop counter, sticky irq.

module error_slot #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              pulse,
    input  logic [DATA_W-1:0] pulse_data,
    input  logic              grant,
    output logic              pending,
    output logic [DATA_W-1:0] data,
    output logic              drop
);
    logic load;

    // An occupied slot can only take a new report if it is being drained this cycle.
    assign drop = pulse & pending & ~grant;
    assign load = pulse & ~drop;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pending <= 1'b0;
            data    <= '0;
        end else if (load) begin
            pending <= 1'b1;
            data    <= pulse_data;
        end else if (grant) begin
            pending <= 1'b0;
        end
    end
endmodule

module error_buffer_ctrl #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8,
    localparam int SRC_W = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [NREQ-1:0]        err_valid,
    input  logic [NREQ*DATA_W-1:0] err_data,
    input  logic                   buf_full,
    output logic                   buf_wr_en,
    output logic [SRC_W+DATA_W-1:0] buf_wr_data,
    output logic [CNT_W-1:0]       drop_count,
    input  logic                   clear,
    output logic                   err_irq
);
    localparam int SUM_W = CNT_W + 4;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [NREQ-1:0]             pending_valid;
    logic [NREQ-1:0][DATA_W-1:0] pending_data;
    logic [NREQ-1:0]             grant_vec;
    logic [NREQ-1:0]             drop_vec;
    logic [SRC_W-1:0]            rr_ptr;
    logic [SRC_W-1:0]            gnt_idx;
    logic [SRC_W-1:0]            cand;
    logic                        gnt_found;
    logic [SUM_W-1:0]            drop_sum;
    logic [SUM_W-1:0]            cnt_total;
    logic [CNT_W-1:0]            cnt_base;

    genvar i;
    generate
        for (i = 0; i < NREQ; i++) begin : g_slot
            error_slot #(.DATA_W(DATA_W)) u_slot (
                .clk        (clk),
                .n_rst      (n_rst),
                .pulse      (err_valid[i]),
                .pulse_data (err_data[i*DATA_W +: DATA_W]),
                .grant      (grant_vec[i]),
                .pending    (pending_valid[i]),
                .data       (pending_data[i]),
                .drop       (drop_vec[i])
            );
        end
    endgenerate

    function automatic logic [SRC_W-1:0] wrap_idx(input logic [SRC_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return SRC_W'(s);
    endfunction

    // Search upward from rr_ptr; the first pending source wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        grant_vec = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = wrap_idx(rr_ptr, k);
            if (!buf_full && !gnt_found && pending_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
        if (gnt_found) grant_vec[gnt_idx] = 1'b1;
    end

    assign buf_wr_en   = gnt_found;
    assign buf_wr_data = gnt_found ? {gnt_idx, pending_data[gnt_idx]} : '0;

    always_comb begin
        drop_sum = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (drop_vec[k]) drop_sum = drop_sum + 1'b1;
        end
    end

    assign cnt_base  = clear ? '0 : drop_count;
    assign cnt_total = SUM_W'(cnt_base) + drop_sum;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rr_ptr     <= '0;
            drop_count <= '0;
            err_irq    <= 1'b0;
        end else begin
            if (gnt_found)
                rr_ptr <= (gnt_idx == SRC_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            drop_count <= (cnt_total > CNT_MAX) ? {CNT_W{1'b1}} : cnt_total[CNT_W-1:0];
            // A write in the same cycle as clear keeps the flag set.
            err_irq    <= buf_wr_en | (err_irq & ~clear);
        end
    end
endmodule

// File: tb/tb_error_buffer_ctrl.sv
// Directed, table-driven bench for error_buffer_ctrl (NREQ=3, DATA_W=16, CNT_W=8).

module tb_error_buffer_ctrl;
    logic        clk;
    logic        n_rst;
    logic [2:0]  err_valid;
    logic [47:0] err_data;
    logic        buf_full;
    logic        buf_wr_en;
    logic [17:0] buf_wr_data;
    logic [7:0]  drop_count;
    logic        clear;
    logic        err_irq;

    int n_cmp;
    int n_bad;

    error_buffer_ctrl #(.NREQ(3), .DATA_W(16), .CNT_W(8)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .err_valid   (err_valid),
        .err_data    (err_data),
        .buf_full    (buf_full),
        .buf_wr_en   (buf_wr_en),
        .buf_wr_data (buf_wr_data),
        .drop_count  (drop_count),
        .clear       (clear),
        .err_irq     (err_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  v;
        logic [47:0] d;
        logic        full;
        logic        clr;
        logic        en;
        logic [17:0] wd;
        logic [7:0]  dc;
        logic        irq;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(logic [2:0] v, logic [47:0] d, logic full, logic clr,
                                logic en, logic [17:0] wd, logic [7:0] dc, logic irq);
        vec_t r;
        r.v = v; r.d = d; r.full = full; r.clr = clr;
        r.en = en; r.wd = wd; r.dc = dc; r.irq = irq;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic en, input logic [17:0] wd,
                              input logic [7:0] dc, input logic irq);
        chk({tag, ".wr_en"}, 32'(buf_wr_en), 32'(en));
        chk({tag, ".wr_data"}, 32'(buf_wr_data), 32'(wd));
        chk({tag, ".drop_count"}, 32'(drop_count), 32'(dc));
        chk({tag, ".irq"}, 32'(err_irq), 32'(irq));
    endtask

    task automatic drive(input logic [2:0] v, input logic [47:0] d, input logic full, input logic clr);
        err_valid = v; err_data = d; buf_full = full; clear = clr;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        n_rst = 1'b0;
        drive(3'b000, '0, 1'b0, 1'b0);

        // Rows: inputs this cycle, outputs observed before the closing edge.
        tbl[0]  = mk(3'b111, {16'h3333, 16'h2222, 16'h1111}, 0, 0, 0, 18'h00000, 0, 0);
        tbl[1]  = mk(3'b000, 48'h0, 0, 0, 1, 18'h01111, 0, 0);
        tbl[2]  = mk(3'b000, 48'h0, 0, 0, 1, 18'h12222, 0, 1);
        tbl[3]  = mk(3'b000, 48'h0, 0, 0, 1, 18'h23333, 0, 1);
        tbl[4]  = mk(3'b111, {16'h6666, 16'h5555, 16'h4444}, 0, 0, 0, 18'h00000, 0, 1);
        tbl[5]  = mk(3'b000, 48'h0, 0, 0, 1, 18'h04444, 0, 1);
        tbl[6]  = mk(3'b000, 48'h0, 0, 0, 1, 18'h15555, 0, 1);
        tbl[7]  = mk(3'b000, 48'h0, 0, 1, 1, 18'h26666, 0, 1);
        tbl[8]  = mk(3'b000, 48'h0, 0, 0, 0, 18'h00000, 0, 1);
        tbl[9]  = mk(3'b000, 48'h0, 0, 1, 0, 18'h00000, 0, 1);
        tbl[10] = mk(3'b000, 48'h0, 0, 0, 0, 18'h00000, 0, 0);
        tbl[11] = mk(3'b010, {16'h0000, 16'hBEEF, 16'h0000}, 0, 0, 0, 18'h00000, 0, 0);
        tbl[12] = mk(3'b000, 48'h0, 0, 0, 1, 18'h1BEEF, 0, 0);
        tbl[13] = mk(3'b000, 48'h0, 0, 0, 0, 18'h00000, 0, 1);
        tbl[14] = mk(3'b000, 48'h0, 0, 1, 0, 18'h00000, 0, 1);
        tbl[15] = mk(3'b000, 48'h0, 0, 0, 0, 18'h00000, 0, 0);
        tbl[16] = mk(3'b001, {16'h0000, 16'h0000, 16'h0001}, 1, 0, 0, 18'h00000, 0, 0);
        tbl[17] = mk(3'b001, {16'h0000, 16'h0000, 16'h0002}, 1, 0, 0, 18'h00000, 0, 0);
        tbl[18] = mk(3'b000, 48'h0, 0, 0, 1, 18'h00001, 1, 0);
        tbl[19] = mk(3'b000, 48'h0, 0, 0, 0, 18'h00000, 1, 1);
        tbl[20] = mk(3'b010, {16'h0000, 16'h0055, 16'h0000}, 0, 0, 0, 18'h00000, 1, 1);
        tbl[21] = mk(3'b010, {16'h0000, 16'h00AA, 16'h0000}, 0, 0, 1, 18'h10055, 1, 1);
        tbl[22] = mk(3'b000, 48'h0, 0, 0, 1, 18'h100AA, 1, 1);
        tbl[23] = mk(3'b000, 48'h0, 0, 0, 0, 18'h00000, 1, 1);

        #1;
        check_outs("reset", 0, 18'h0, 8'h0, 0);
        @(negedge clk);
        n_rst = 1'b1;
        tick();

        for (int r = 0; r < 24; r++) begin
            drive(tbl[r].v, tbl[r].d, tbl[r].full, tbl[r].clr);
            #1;
            check_outs($sformatf("row%0d", r), tbl[r].en, tbl[r].wd, tbl[r].dc, tbl[r].irq);
            tick();
        end

        // Saturation: fill every slot under backpressure, then overrun them repeatedly.
        drive(3'b111, {16'h0C0C, 16'h0B0B, 16'h0A0A}, 1'b1, 1'b0);
        tick();
        for (int c = 0; c < 86; c++) begin
            drive(3'b111, {16'hFFFF, 16'hEEEE, 16'hDDDD}, 1'b1, 1'b0);
            tick();
        end
        drive(3'b000, '0, 1'b1, 1'b0);
        #1;
        chk("sat.drop_count", 32'(drop_count), 32'd255);
        chk("sat.wr_en_full", 32'(buf_wr_en), 32'd0);
        tick();
        chk("sat.hold", 32'(drop_count), 32'd255);

        // Clear in the same cycle as two drops: result is just those two.
        drive(3'b011, {16'h0000, 16'h1234, 16'h5678}, 1'b1, 1'b1);
        tick();
        drive(3'b000, '0, 1'b1, 1'b0);
        #1;
        chk("clr_drop.drop_count", 32'(drop_count), 32'd2);
        chk("clr_drop.irq", 32'(err_irq), 32'd0);

        // Asynchronous reset while all slots are pending and rr_ptr is non-zero.
        drive(3'b000, '0, 1'b0, 1'b0);
        n_rst = 1'b0;
        #1;
        check_outs("async_rst", 0, 18'h0, 8'h0, 0);
        tick();
        check_outs("in_rst", 0, 18'h0, 8'h0, 0);
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        chk("post_rst.wr_en", 32'(buf_wr_en), 32'd0);
        drive(3'b101, {16'h0C0C, 16'h0000, 16'h0A0A}, 1'b0, 1'b0);
        tick();
        drive(3'b000, '0, 1'b0, 1'b0);
        #1;
        chk("post_rst.first_grant", 32'(buf_wr_data), 32'h00A0A);
        chk("post_rst.first_en", 32'(buf_wr_en), 32'd1);
        tick();
        chk("post_rst.second_grant", 32'(buf_wr_data), 32'h20C0C);
        tick();
        chk("post_rst.idle", 32'(buf_wr_en), 32'd0);
        chk("post_rst.irq", 32'(err_irq), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/error_buffer_ctrl.md
# error_buffer_ctrl

Front-end scheduler for `error_buffer`: collects single-cycle error pulses from NREQ independent detectors (ECC, CRC, timing checkers), holds one pending report per source, and round-robin arbitrates them into the buffer's write port under `buf_full` backpressure. It tags each entry with its source ID, counts reports lost to per-source overrun (saturating), and raises a sticky interrupt whenever an entry is written. It sits between the controller's error detectors and `error_buffer`, one write per cycle maximum.

## Interface
- NREQ, 3 — number of error sources; legal range 2..8
- DATA_W, 16 — error payload width per source
- CNT_W, 8 — drop counter width
- SRC_W (localparam) = $clog2(NREQ)
- clk  input  1  system clock; all state updates on rising edge
- n_rst  input  1  asynchronous, active-low reset
- err_valid  input  NREQ  per-source single-cycle error pulse
- err_data  input  NREQ*DATA_W  payloads; source i occupies bits [i*DATA_W +: DATA_W]; sampled only when err_valid[i]=1
- buf_full  input  1  error_buffer cannot accept a write this cycle
- buf_wr_en  output  1  write strobe to error_buffer
- buf_wr_data  output  SRC_W+DATA_W  {src_id, payload}
- drop_count  output  CNT_W  reports lost to overrun, saturating
- clear  input  1  synchronous clear of drop_count and err_irq
- err_irq  output  1  sticky "new entry written" flag

## Operation
- Per source i: pending_valid[i] and pending_data[i] (one-deep slot).
- Capture: err_valid[i]=1 loads pending_data[i] and sets pending_valid[i], unless the slot is occupied and not granted this cycle. In that case the new report is dropped, the old one is kept, and the drop is counted.
- Slot granted in the same cycle a new pulse arrives: slot reloads with the new payload and stays valid. This is not a drop.
- Arbitration (combinational): if buf_full=0 and any pending_valid, grant the first pending source at or after rr_ptr, searching upward modulo NREQ.
- On grant g: buf_wr_en=1, buf_wr_data={g[SRC_W-1:0], pending_data[g]}, pending_valid[g] clears at the edge (unless reloaded), rr_ptr <= (g+1) mod NREQ.
- No grant: buf_wr_en=0, buf_wr_data=0, rr_ptr holds.
- buf_full=1: no grant; pending slots hold; new pulses into occupied slots drop.
- drop_count next = sat((clear ? 0 : drop_count) + number of drops this cycle). Multiple sources may drop in one cycle, and each is counted. Saturates at 2^CNT_W−1 and never wraps.
- err_irq next = buf_wr_en | (err_irq & ~clear). If a write and clear occur in the same cycle, set wins.

## Timing
- Reset values: pending_valid=0, pending_data=0, rr_ptr=0, drop_count=0, err_irq=0. This gives buf_wr_en=0 and buf_wr_data=0 during and immediately after reset.
- Reset is asserted asynchronously mid-operation: all pending reports are discarded and no write is issued while n_rst=0.
- Latency: pulse at edge N is captured, and buf_wr_en can assert in the cycle after edge N, i.e. one cycle of latency if uncontended and not full.
- buf_wr_en/buf_wr_data are combinational from registered state and buf_full. error_buffer samples them on the same edge that clears the slot.
- err_irq rises one cycle after the first buf_wr_en. drop_count updates one cycle after the dropping pulse.
- Throughput: one entry per cycle. With all NREQ slots pending and buf_full=0, grants rotate, and each source is served within NREQ cycles.

## Test plan
- Reset: hold n_rst=0 mid-stream with slots pending → all outputs 0. After release, first grant goes to source 0 even if source 2 is also pending.
- Single report: err_valid=3'b010, err_data[31:16]=16'hBEEF → next cycle buf_wr_en=1, buf_wr_data={2'd1,16'hBEEF}. One cycle later err_irq=1. Apply clear → err_irq=0.
- Round-robin: pulse all 3 sources together with buf_full=0 → writes from src 0, 1, 2 on consecutive cycles. Pulse all 3 again → order restarts at src 0 (rr_ptr=0 after src 2).
- Backpressure and drop: buf_full=1, pulse src0 with 16'h0001 then src0 with 16'h0002 → drop_count=1 and the slot keeps 16'h0001. Release buf_full → write {0,16'h0001}.
- Simultaneous grant and reload: src1 pending and granted in cycle N while a new pulse 16'h00AA arrives → no drop, and the next cycle writes {1,16'h00AA}.
- Saturation and clear priority: CNT_W=8, force 256+ drops → drop_count holds at 255. clear asserted in the same cycle as 2 drops → drop_count=2. A write in the same cycle as clear → err_irq stays 1.
